rhs_cmd_sequencer: RTL and testbench
====================================

Name: rhs_cmd_sequencer

Overview:
- Command sequencer that sits directly upstream of the RHS SPI master.
- Issues a repeating frame of 32-bit commands: NUM_CHANNELS CONVERT commands followed by two auxiliary commands. It pulses the master's start and holds data_in stable for each transaction.
- Captures each returned data_out word, tags it with the command slot that produced it (RHS results lag by two commands) and presents it on a valid/ready sample stream to downstream logic.

Parameters:
- NUM_CHANNELS, 16, CONVERT slots per frame (1..62).
- AUX_CMD0, 32'hFF00_0000, command issued in slot NUM_CHANNELS.
- AUX_CMD1, 32'hFF00_0000, command issued in slot NUM_CHANNELS+1.
- TIMEOUT_CYCLES, 1023, max clk cycles from spi_start to spi_done rising before abort.

Ports:
- clk  in  1  system clock (same clock as SPI master)
- rstn  in  1  synchronous active-low reset
- enable  in  1  run frames back-to-back while high
- spi_start  out  1  one-cycle start pulse to SPI master
- spi_data_in  out  32  command word to SPI master, held for whole transaction
- spi_data_out  in  32  word returned by SPI master
- spi_done  in  1  SPI master done (level, several cycles long)
- sample_data  out  32  captured result word
- sample_tag  out  6  slot index whose command produced sample_data
- sample_valid  out  1  sample_data/sample_tag valid
- sample_ready  in  1  downstream accepts when valid&&ready
- frame_done  out  1  one-cycle pulse after last slot of a frame completes
- frame_count  out  16  completed frames, wraps 16'hFFFF->0
- overflow  out  1  sticky: result arrived while previous sample not yet accepted
- timeout_err  out  1  sticky: spi_done not seen within TIMEOUT_CYCLES
- active  out  1  high in any state except IDLE

Behaviour:
- Reset (rstn=0 at posedge clk): state=IDLE; all outputs 0, including spi_data_in, frame_count, overflow and timeout_err. Slot counter 0, prime counter 0, timeout counter 0. Reset mid-transaction aborts immediately; the SPI master shares rstn.
- Frame length F=NUM_CHANNELS+2. Slot s command:
  - s<NUM_CHANNELS: CONVERT = {2'b00, 8'h00, s[5:0], 16'h0000}.
  - s=NUM_CHANNELS: AUX_CMD0.
  - s=NUM_CHANNELS+1: AUX_CMD1.
- FSM states:
  - IDLE: if enable, go to ISSUE with slot=0 and prime=0.
  - ISSUE (1 cycle): spi_data_in<=cmd(slot), registered so it is stable before and through start; spi_start=1 for exactly this cycle; timeout counter cleared; go to WAIT_DONE.
  - WAIT_DONE: on first cycle with spi_done=1, latch spi_data_out and go to CAPTURE. If the timeout counter reaches TIMEOUT_CYCLES first, set timeout_err and go to IDLE; sample_valid is unaffected.
  - CAPTURE (1 cycle):
    - Result tag = (slot+F-2) mod F.
    - If prime<2: discard the result and increment prime; these are stale results from before leaving IDLE.
    - Else if sample_valid&&!sample_ready: set overflow and drop the new result; the held sample is kept.
    - Else load sample_data/sample_tag and set sample_valid.
    - If slot==F-1: pulse frame_done and frame_count+=1.
    - Go to RELEASE.
  - RELEASE: wait for spi_done=0, which means the master is back in READY.
    - Then, if slot==F-1: slot=0; go to ISSUE if enable else IDLE.
    - Else slot+=1 and go to ISSUE; enable low mid-frame does not stop the frame.
- Sample handshake: sample_valid clears on valid&&ready unless CAPTURE loads a new sample in the same cycle, in which case the new sample replaces it with no overflow. sample_data/sample_tag stay stable while valid&&!ready.
- Prime counter is reset only on IDLE->ISSUE. Back-to-back frames keep the pipeline primed, so slot 0/1 results carry tags F-2/F-1 from the previous frame.
- frame_done and spi_start are never high in the same cycle.
- Sticky flags clear only on reset.
- active=0 only in IDLE.
- frame_count increments regardless of sample drops.

Test Plan:
- NUM_CHANNELS=4 (F=6), sample_ready=1, enable held for 2 frames -> 12 spi_start pulses. spi_data_in slot 2 = 32'h0002_0000. First 2 results discarded. Tags out 0,1,2,3,4,5,0,1,2,3. frame_done pulses twice; frame_count=2.
- Bench SPI model returns data_out = 32'hA000_0000|slot_issued; check sample_data for tag t equals 32'hA000_0000|t across frame boundary (tags 4,5 delivered during slots 0,1 of next frame).
- sample_ready=0 throughout frame 1 -> only the first non-discarded sample (tag 0) is held stable; overflow=1 after next capture; no further sample_valid changes until ready asserted.
- enable dropped during slot 2 -> frame completes through slot 5, frame_done pulses, FSM enters IDLE, active=0. Re-enable -> prime restarts (2 discards before tag 0).
- Model never asserts spi_done, TIMEOUT_CYCLES=50 -> timeout_err=1 exactly 50 cycles after spi_start, state IDLE, no sample_valid.
- rstn=0 for 1 cycle while in WAIT_DONE of slot 3 -> all outputs 0 next cycle, frame_count=0; with enable high, next spi_start carries slot 0 command.

Source files
------------

// File: rtl/rhs_cmd_sequencer.sv
// Command sequencer for the RHS SPI master: issues repeating CONVERT/AUX frames
// and returns each result word tagged with the slot whose command produced it.
module rhs_cmd_sequencer #(
    parameter int          NUM_CHANNELS   = 16,
    parameter logic [31:0] AUX_CMD0       = 32'hFF00_0000,
    parameter logic [31:0] AUX_CMD1       = 32'hFF00_0000,
    parameter int          TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    output logic        spi_start,
    output logic [31:0] spi_data_in,
    input  logic [31:0] spi_data_out,
    input  logic        spi_done,
    output logic [31:0] sample_data,
    output logic [5:0]  sample_tag,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        overflow,
    output logic        timeout_err,
    output logic        active
);

    localparam int         FRAME_LEN = NUM_CHANNELS + 2;
    localparam logic [5:0] NCH       = 6'(NUM_CHANNELS);
    localparam logic [5:0] LAST_SLOT = 6'(FRAME_LEN - 1);
    localparam int         TW        = $clog2(TIMEOUT_CYCLES + 2) + 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        CAPTURE,
        RELEASE
    } state_t;

    state_t        state, next_state;
    logic [5:0]    slot, next_slot;
    logic [1:0]    prime;
    logic [TW-1:0] tcount;
    logic [TW-1:0] elapsed;
    logic [31:0]   result;
    logic [6:0]    tag_sum;
    logic [5:0]    capture_tag;
    logic          timed_out;

    function automatic logic [31:0] slot_cmd(input logic [5:0] s);
        if (s < NCH)
            return {2'b00, 8'h00, s, 16'h0000};
        else if (s == NCH)
            return AUX_CMD0;
        else
            return AUX_CMD1;
    endfunction

    // tcount is zero in the first WAIT_DONE cycle, which is already two cycles past the start edge
    assign elapsed     = tcount + TW'(2);
    assign tag_sum     = {1'b0, slot} + 7'(FRAME_LEN - 2);
    assign capture_tag = (tag_sum >= 7'(FRAME_LEN)) ? 6'(tag_sum - 7'(FRAME_LEN)) : tag_sum[5:0];
    assign spi_start   = (state == ISSUE);
    assign active      = (state != IDLE);

    always_comb begin
        next_state = state;
        next_slot  = slot;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    next_state = ISSUE;
                    next_slot  = 6'd0;
                end
            end
            ISSUE: next_state = WAIT_DONE;
            WAIT_DONE: begin
                if (spi_done) begin
                    next_state = CAPTURE;
                end else if (elapsed >= TW'(TIMEOUT_CYCLES)) begin
                    next_state = IDLE;
                    timed_out  = 1'b1;
                end
            end
            CAPTURE: next_state = RELEASE;
            RELEASE: begin
                // a frame, once started, always runs to its last slot
                if (!spi_done) begin
                    if (slot == LAST_SLOT) begin
                        next_slot  = 6'd0;
                        next_state = enable ? ISSUE : IDLE;
                    end else begin
                        next_slot  = slot + 6'd1;
                        next_state = ISSUE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            slot         <= 6'd0;
            prime        <= 2'd0;
            tcount       <= '0;
            result       <= 32'd0;
            spi_data_in  <= 32'd0;
            sample_data  <= 32'd0;
            sample_tag   <= 6'd0;
            sample_valid <= 1'b0;
            frame_done   <= 1'b0;
            frame_count  <= 16'd0;
            overflow     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state      <= next_state;
            slot       <= next_slot;
            frame_done <= 1'b0;

            if (state == IDLE && next_state == ISSUE)
                prime <= 2'd0;
            // command word is set up one cycle ahead so it is stable when start rises
            if (next_state == ISSUE)
                spi_data_in <= slot_cmd(next_slot);
            if (state == ISSUE)
                tcount <= '0;
            else if (state == WAIT_DONE)
                tcount <= tcount + TW'(1);
            if (state == WAIT_DONE && spi_done)
                result <= spi_data_out;
            if (timed_out)
                timeout_err <= 1'b1;

            if (sample_valid && sample_ready)
                sample_valid <= 1'b0;

            // the first two results after leaving IDLE belong to commands issued before it
            if (state == CAPTURE) begin
                if (prime < 2'd2) begin
                    prime <= prime + 2'd1;
                end else if (sample_valid && !sample_ready) begin
                    overflow <= 1'b1;
                end else begin
                    sample_data  <= result;
                    sample_tag   <= capture_tag;
                    sample_valid <= 1'b1;
                end
                if (slot == LAST_SLOT) begin
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rhs_cmd_sequencer.sv
// Directed bench for rhs_cmd_sequencer with a small RHS-like SPI master model
// whose results lag the issued commands by two transactions.
module tb_rhs_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        spi_start;
    logic [31:0] spi_data_in;
    logic [31:0] spi_data_out;
    logic        spi_done;
    logic [31:0] sample_data;
    logic [5:0]  sample_tag;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        overflow;
    logic        timeout_err;
    logic        active;

    int checks = 0;
    int failures = 0;

    logic model_hang = 1'b0;

    int          start_cnt = 0;
    int          fd_cnt = 0;
    int          dbl_start = 0;
    int          both_high = 0;
    int          stall_changes = 0;
    logic [5:0]  tag_q[$];
    logic [31:0] data_q[$];
    logic [31:0] cmd_q[$];

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] data;
    } sample_vec_t;

    typedef struct {
        int          slot;
        logic [31:0] cmd;
    } cmd_vec_t;

    sample_vec_t exp_samples[10];
    cmd_vec_t    exp_cmds[6];

    rhs_cmd_sequencer #(
        .NUM_CHANNELS  (4),
        .AUX_CMD0      (32'hFF00_0000),
        .AUX_CMD1      (32'hFF00_0000),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .enable      (enable),
        .spi_start   (spi_start),
        .spi_data_in (spi_data_in),
        .spi_data_out(spi_data_out),
        .spi_done    (spi_done),
        .sample_data (sample_data),
        .sample_tag  (sample_tag),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .active      (active)
    );

    always #5 clk = ~clk;

    // SPI master model: done rises 3 cycles after start, lasts 3 cycles, returns slot issued two starts earlier
    initial begin
        logic [5:0]  h1, h2, cur, last_slot;
        logic [31:0] pending;
        int          mcnt;
        logic        mbusy;
        spi_done = 1'b0;
        spi_data_out = 32'd0;
        h1 = 6'h3F;
        h2 = 6'h3F;
        last_slot = 6'd0;
        pending = 32'd0;
        mcnt = 0;
        mbusy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!active) begin
                mbusy = 1'b0;
                spi_done = 1'b0;
            end else if (spi_start) begin
                if (spi_data_in[31:30] == 2'b00)
                    cur = spi_data_in[21:16];
                else
                    cur = last_slot + 6'd1;
                last_slot = cur;
                pending = 32'hA000_0000 | {26'd0, h2};
                h2 = h1;
                h1 = cur;
                mbusy = 1'b1;
                mcnt = 0;
            end else if (mbusy && !model_hang) begin
                mcnt++;
                if (mcnt == 3) begin
                    spi_done = 1'b1;
                    spi_data_out = pending;
                end else if (mcnt == 6) begin
                    spi_done = 1'b0;
                    mbusy = 1'b0;
                end
            end
        end
    end

    // Passive monitor: records accepted samples, issued commands and protocol anomalies
    initial begin
        logic        prev_start, prev_valid, prev_ready;
        logic [31:0] prev_data;
        logic [5:0]  prev_tag;
        prev_start = 1'b0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_data = 32'd0;
        prev_tag = 6'd0;
        forever begin
            @(negedge clk);
            if (spi_start) begin
                start_cnt++;
                cmd_q.push_back(spi_data_in);
                if (prev_start) dbl_start++;
            end
            if (frame_done) fd_cnt++;
            if (frame_done && spi_start) both_high++;
            if (sample_valid && sample_ready) begin
                tag_q.push_back(sample_tag);
                data_q.push_back(sample_data);
            end
            if (rstn && prev_valid && !prev_ready &&
                (!sample_valid || sample_data != prev_data || sample_tag != prev_tag))
                stall_changes++;
            prev_start = spi_start;
            prev_valid = sample_valid;
            prev_ready = sample_ready;
            prev_data = sample_data;
            prev_tag = sample_tag;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic rdy);
        enable = en;
        sample_ready = rdy;
    endtask

    task automatic applyReset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic waitUntilIdle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (active && n < 5000);
        checkOutput(name, 32'(active), 32'd0);
    endtask

    task automatic waitStartsAtLeast(input string name, input int base, input int target);
        int n;
        n = 0;
        while ((start_cnt - base) < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'((start_cnt - base) >= target), 32'd1);
    endtask

    task automatic waitForStart(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!spi_start && n < 3000);
        checkOutput(name, 32'(spi_start), 32'd1);
    endtask

    initial begin
        int s_base, f_base, q_base, c_base, st_base, n, hits;

        exp_samples[0] = '{6'd0, 32'hA000_0000};
        exp_samples[1] = '{6'd1, 32'hA000_0001};
        exp_samples[2] = '{6'd2, 32'hA000_0002};
        exp_samples[3] = '{6'd3, 32'hA000_0003};
        exp_samples[4] = '{6'd4, 32'hA000_0004};
        exp_samples[5] = '{6'd5, 32'hA000_0005};
        exp_samples[6] = '{6'd0, 32'hA000_0000};
        exp_samples[7] = '{6'd1, 32'hA000_0001};
        exp_samples[8] = '{6'd2, 32'hA000_0002};
        exp_samples[9] = '{6'd3, 32'hA000_0003};
        exp_cmds[0] = '{0, 32'h0000_0000};
        exp_cmds[1] = '{1, 32'h0001_0000};
        exp_cmds[2] = '{2, 32'h0002_0000};
        exp_cmds[3] = '{3, 32'h0003_0000};
        exp_cmds[4] = '{4, 32'hFF00_0000};
        exp_cmds[5] = '{5, 32'hFF00_0000};

        applyStimulus(1'b0, 1'b1);
        applyReset();
        checkOutput("rst_active", 32'(active), 32'd0);
        checkOutput("rst_spi_start", 32'(spi_start), 32'd0);
        checkOutput("rst_spi_data_in", spi_data_in, 32'd0);
        checkOutput("rst_sample_valid", 32'(sample_valid), 32'd0);
        checkOutput("rst_frame_count", 32'(frame_count), 32'd0);
        checkOutput("rst_flags", {30'd0, overflow, timeout_err}, 32'd0);

        // two back-to-back frames, enable dropped during the second
        s_base = start_cnt; f_base = fd_cnt; q_base = tag_q.size(); c_base = cmd_q.size();
        applyStimulus(1'b1, 1'b1);
        waitStartsAtLeast("f2_reached", s_base, 8);
        applyStimulus(1'b0, 1'b1);
        waitUntilIdle("f2_idle");
        checkOutput("f2_starts", 32'(start_cnt - s_base), 32'd12);
        checkOutput("f2_frame_done", 32'(fd_cnt - f_base), 32'd2);
        checkOutput("f2_frame_count", 32'(frame_count), 32'd2);
        checkOutput("f2_sample_cnt", 32'(tag_q.size() - q_base), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (q_base + i < tag_q.size()) begin
                checkOutput($sformatf("f2_tag%0d", i), 32'(tag_q[q_base + i]), 32'(exp_samples[i].tag));
                checkOutput($sformatf("f2_data%0d", i), data_q[q_base + i], exp_samples[i].data);
            end
        end
        for (int i = 0; i < 6; i++) begin
            if (c_base + i < cmd_q.size())
                checkOutput($sformatf("cmd_slot%0d", exp_cmds[i].slot), cmd_q[c_base + i], exp_cmds[i].cmd);
        end

        // re-enable, then drop enable during slot 2: frame finishes and priming restarts
        s_base = start_cnt; f_base = fd_cnt; q_base = tag_q.size();
        applyStimulus(1'b1, 1'b1);
        waitStartsAtLeast("re_slot2", s_base, 3);
        applyStimulus(1'b0, 1'b1);
        waitUntilIdle("re_idle");
        checkOutput("re_starts", 32'(start_cnt - s_base), 32'd6);
        checkOutput("re_frame_done", 32'(fd_cnt - f_base), 32'd1);
        checkOutput("re_frame_count", 32'(frame_count), 32'd3);
        checkOutput("re_sample_cnt", 32'(tag_q.size() - q_base), 32'd4);
        if (tag_q.size() > q_base)
            checkOutput("re_first_tag", 32'(tag_q[q_base]), 32'd0);

        // downstream stalled for a whole frame
        applyStimulus(1'b0, 1'b0);
        applyReset();
        st_base = stall_changes;
        applyStimulus(1'b1, 1'b0);
        waitForStart("ov_start");
        applyStimulus(1'b0, 1'b0);
        n = 0;
        while (!sample_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ov_first_valid", 32'(sample_valid), 32'd1);
        checkOutput("ov_first_tag", 32'(sample_tag), 32'd0);
        checkOutput("ov_before", 32'(overflow), 32'd0);
        n = 0;
        while (!frame_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ov_frame_done", 32'(frame_done), 32'd1);
        checkOutput("ov_after", 32'(overflow), 32'd1);
        checkOutput("ov_held_valid", 32'(sample_valid), 32'd1);
        checkOutput("ov_held_tag", 32'(sample_tag), 32'd0);
        checkOutput("ov_held_data", sample_data, 32'hA000_0000);
        waitUntilIdle("ov_idle");
        checkOutput("ov_stable", 32'(stall_changes - st_base), 32'd0);
        applyStimulus(1'b0, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("ov_drained", 32'(sample_valid), 32'd0);

        // master never answers
        applyStimulus(1'b0, 1'b1);
        applyReset();
        model_hang = 1'b1;
        applyStimulus(1'b1, 1'b1);
        waitForStart("to_start");
        applyStimulus(1'b0, 1'b1);
        n = 0;
        while (!timeout_err && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("to_latency", 32'(n), 32'd50);
        checkOutput("to_active", 32'(active), 32'd0);
        checkOutput("to_no_sample", 32'(sample_valid), 32'd0);
        model_hang = 1'b0;
        @(negedge clk);

        // reset while waiting on slot 3 of the second frame, sticky timeout still set
        applyStimulus(1'b1, 1'b1);
        hits = 0;
        n = 0;
        while (hits < 2 && n < 5000) begin
            @(negedge clk);
            n++;
            if (spi_start && spi_data_in == 32'h0003_0000) hits++;
        end
        checkOutput("mr_reached", 32'(hits), 32'd2);
        @(negedge clk);
        checkOutput("mr_pre_count", 32'(frame_count), 32'd1);
        checkOutput("mr_pre_timeout", 32'(timeout_err), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        checkOutput("mr_active", 32'(active), 32'd0);
        checkOutput("mr_spi_data_in", spi_data_in, 32'd0);
        checkOutput("mr_sample_valid", 32'(sample_valid), 32'd0);
        checkOutput("mr_sample_data", sample_data, 32'd0);
        checkOutput("mr_frame_count", 32'(frame_count), 32'd0);
        checkOutput("mr_timeout", 32'(timeout_err), 32'd0);
        waitForStart("mr_restart");
        checkOutput("mr_restart_cmd", spi_data_in, 32'h0000_0000);
        applyStimulus(1'b0, 1'b1);
        waitUntilIdle("mr_idle");

        checkOutput("start_one_cycle", 32'(dbl_start), 32'd0);
        checkOutput("done_not_with_start", 32'(both_high), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
